hsv_core_fetch: RTL

//  Front-end producer of the fetch->decode interface: generates sequential PCs, issues instruction reads
//  to the imem port, buffers in-order responses and presents fetch_data_t to decode via valid/ready.

---
 rtl/hsv_core_pkg.sv | 15 +
 rtl/hsv_core_fetch_fifo.sv | 48 ++++
 rtl/hsv_core_fetch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/hsv_core_pkg.sv
// Types shared between the fetch stage and decode.
package hsv_core_pkg;

    typedef logic [31:0] word;

    typedef struct packed {
        word  insn;
        word  pc;
        logic fault;
    } fetch_data_t;

    localparam int  FETCH_DATA_W = $bits(fetch_data_t);
    localparam word PC_STEP      = 32'd4;

endpackage

// File: rtl/hsv_core_fetch_fifo.sv
// Synchronous response buffer: registered storage, head visible on data_o, clear beats push/pop.
module hsv_core_fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + 1'b1;
            if (pop_i)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/hsv_core_fetch.sv
// Fetch front end: sequential PC generation with credit-limited imem requests, in-order response
// buffering, flush redirect with stale-response discard, and bus-error fault tagging.
module hsv_core_fetch
    import hsv_core_pkg::*;
#(
    parameter word RESET_PC   = 32'h0000_0000,
    parameter int  FIFO_DEPTH = 4
) (
    input  logic        clk_core,
    input  logic        rst_core,
    input  logic        flush_req,
    input  word         flush_pc,
    output logic        flush_ack,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output word         mem_req_addr,
    input  logic        mem_rsp_valid,
    input  word         mem_rsp_data,
    input  logic        mem_rsp_error,
    input  logic        ready_i,
    output logic        valid_o,
    output fetch_data_t fetch_data
);

    localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic        req_vld_q, req_vld_d;
    word         req_pc_q, req_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d;
    logic        halted_q, halted_d, ack_q, ack_d;
    logic        accept, stalled, push, pop, fifo_empty;
    logic [CW-1:0] fifo_count, count_nxt;
    fetch_data_t push_data;
    word         flush_pc_al;

    assign accept      = req_vld_q & mem_req_ready;
    assign stalled     = req_vld_q & ~mem_req_ready;
    assign valid_o     = ~fifo_empty & ~flush_req;
    assign pop         = valid_o & ready_i;
    assign flush_pc_al = {flush_pc[31:2], 2'b00};

    always_comb begin
        req_pc_d       = req_pc_q;
        rsp_pc_d       = rsp_pc_q;
        halted_d       = halted_q;
        discard_d      = discard_q;
        push           = 1'b0;
        push_data.insn = mem_rsp_error ? '0 : mem_rsp_data;
        push_data.pc   = rsp_pc_q;
        push_data.fault = mem_rsp_error;
        inflight_d     = inflight_q + CW'(accept) - CW'(mem_rsp_valid);

        if (accept) req_pc_d = req_pc_q + PC_STEP;

        if (flush_req) begin
            // A stalled request keeps its address; the redirect lands once it is accepted.
            if (!stalled) req_pc_d = flush_pc_al;
            rsp_pc_d  = flush_pc_al;
            halted_d  = 1'b0;
            discard_d = inflight_d;
        end else if (mem_rsp_valid) begin
            if (discard_q != '0) begin
                discard_d = discard_q - 1'b1;
            end else begin
                push     = 1'b1;
                rsp_pc_d = rsp_pc_q + PC_STEP;
                if (mem_rsp_error) begin
                    halted_d  = 1'b1;
                    discard_d = inflight_d;
                end
            end
        end

        // Credit counts every slot a response could still need, so the buffer never overflows.
        count_nxt = flush_req ? '0 : fifo_count + CW'(push) - CW'(pop);
        req_vld_d = stalled |
                    (~flush_req & ~halted_d & (({1'b0, inflight_d} + {1'b0, count_nxt}) < DEPTH_C));
        ack_d     = flush_req & ~stalled;
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            req_vld_q  <= 1'b0;
            req_pc_q   <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            halted_q   <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            req_vld_q  <= req_vld_d;
            req_pc_q   <= req_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            halted_q   <= halted_d;
            ack_q      <= ack_d;
        end
    end

    assign mem_req_valid = req_vld_q;
    assign mem_req_addr  = req_pc_q;
    assign flush_ack     = ack_q & flush_req;

    hsv_core_fetch_fifo #(
        .WIDTH (FETCH_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_core),
        .rst_i   (rst_core),
        .clear_i (flush_req),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (fetch_data),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    a_discard_le_inflight: assert property (
        @(posedge clk_core) disable iff (rst_core) discard_q <= inflight_q);

endmodule
